// File: rtl/ball_engine.sv
// ball_engine: Pong ball motion, wall/paddle reflection, miss handling and ball pixel render.
// Ports: iCLK/iRST_N pixel clock and async active-low reset; px/py current pixel from vga_sync;
// iPaddle_x paddle left edge; iLaunch serve request; iPause freeze RUN motion;
// oR/oG/oB registered ball colour; oBall_x/oBall_y ball top-left; oState 0 SERVE/1 RUN/2 MISS;
// oMiss one-cycle ball-lost pulse.
module ball_engine #(
  parameter int BALL_SIZE   = 8,
  parameter int SPEED       = 2,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_W    = 64,
  parameter int MISS_FRAMES = 60
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] iPaddle_x,
  input  logic       iLaunch,
  input  logic       iPause,
  output logic [9:0] oR,
  output logic [9:0] oG,
  output logic [9:0] oB,
  output logic [9:0] oBall_x,
  output logic [9:0] oBall_y,
  output logic [1:0] oState,
  output logic       oMiss
);
  typedef enum logic [1:0] {SERVE = 2'd0, RUN = 2'd1, MISS = 2'd2} state_t;
  localparam int CW = $clog2(MISS_FRAMES + 1);
  localparam logic signed [10:0] SP     = 11'(SPEED);
  localparam logic signed [10:0] BS     = 11'(BALL_SIZE);
  localparam logic signed [10:0] XMAX   = 11'(640 - BALL_SIZE);
  localparam logic signed [10:0] YREST  = 11'(PADDLE_Y - BALL_SIZE);
  localparam logic signed [10:0] PTOP   = 11'(PADDLE_Y);
  localparam logic signed [10:0] XHOME  = 11'((640 - BALL_SIZE) / 2);
  localparam logic signed [11:0] SOFF   = 12'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic signed [11:0] PW     = 12'(PADDLE_W);
  localparam logic signed [11:0] BS12   = 12'(BALL_SIZE);
  localparam logic signed [11:0] XMAX12 = 12'(640 - BALL_SIZE);
  state_t state, state_n;
  logic signed [10:0] x, y, dx, dy, x_n, y_n, dx_n, dy_n, nx, ny;
  logic signed [11:0] x12, y12, pad, spx, spy, serve_x;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0] prev_py, rgb;
  logic tick, miss_n, hit, in_box;
  assign nx      = x + dx;
  assign ny      = y + dy;
  assign x12     = {x[10], x};
  assign y12     = {y[10], y};
  assign pad     = {2'b00, iPaddle_x};
  assign spx     = {2'b00, px};
  assign spy     = {2'b00, py};
  assign serve_x = pad + SOFF;
  // paddle test uses the pre-move x so a ball sliding off the paddle edge this frame still counts
  assign hit = dy > 11'sd0 && y + BS <= PTOP && ny + BS > PTOP && x12 + BS12 > pad && x12 < pad + PW;
  assign in_box = spx >= x12 && spx < x12 + BS12 && spy >= y12 && spy < y12 + BS12;
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    dx_n    = dx;
    dy_n    = dy;
    cnt_n   = cnt;
    miss_n  = 1'b0;
    if (tick)
      case (state)
        SERVE: begin
          x_n = serve_x > XMAX12 ? XMAX : serve_x[10:0];
          y_n = YREST;
          if (iLaunch) begin
            state_n = RUN;
            dx_n    = SP;
            dy_n    = -SP;
          end
        end
        RUN: if (!iPause) begin
          x_n  = nx <= 11'sd0 ? 11'sd0 : nx >= XMAX ? XMAX : nx;
          dx_n = nx <= 11'sd0 ? SP : nx >= XMAX ? -SP : dx;
          if (hit) begin
            y_n  = YREST;
            dy_n = -SP;
          end else if (ny >= 11'sd480) begin
            // lost ball freezes where it was, including X
            state_n = MISS;
            x_n     = x;
            dx_n    = dx;
            cnt_n   = '0;
            miss_n  = 1'b1;
          end else begin
            y_n  = ny <= 11'sd0 ? 11'sd0 : ny;
            dy_n = ny <= 11'sd0 ? SP : dy;
          end
        end
        MISS: begin
          state_n = cnt == CW'(MISS_FRAMES - 1) ? SERVE : MISS;
          cnt_n   = cnt == CW'(MISS_FRAMES - 1) ? '0 : cnt + 1'b1;
        end
        default: state_n = SERVE;
      endcase
  end
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state   <= SERVE;
      x       <= XHOME;
      y       <= YREST;
      dx      <= SP;
      dy      <= -SP;
      cnt     <= '0;
      prev_py <= '0;
      tick    <= 1'b0;
      oMiss   <= 1'b0;
      rgb     <= '0;
    end else begin
      state   <= state_n;
      x       <= x_n;
      y       <= y_n;
      dx      <= dx_n;
      dy      <= dy_n;
      cnt     <= cnt_n;
      prev_py <= py;
      tick    <= prev_py != '0 && py == '0;
      oMiss   <= miss_n;
      rgb     <= in_box ? 10'h3FF : 10'h000;
    end
  assign oR      = rgb;
  assign oG      = rgb;
  assign oB      = rgb;
  assign oBall_x = x[9:0];
  assign oBall_y = y[9:0];
  assign oState  = state;
endmodule

// File: tb/tb_ball_engine.sv
// tb_ball_engine: directed and random frame sequences checked against an integer ball model.
module tb_ball_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] px = '0, py = '0, pad = 10'd100;
  logic       launch = 1'b0, pause = 1'b0;
  logic [9:0] r, g, b, bx, by;
  logic [1:0] st;
  logic       miss;
  int n_chk = 0, n_fail = 0, misses = 0;
  int mx, my, mdx, mdy, mst, mcnt;
  bit mmiss, mhit, done;

  ball_engine dut (
    .iCLK(clk), .iRST_N(rst_n), .px(px), .py(py), .iPaddle_x(pad),
    .iLaunch(launch), .iPause(pause), .oR(r), .oG(g), .oB(b),
    .oBall_x(bx), .oBall_y(by), .oState(st), .oMiss(miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (miss === 1'b1) misses++;
  endtask

  function automatic void model_reset();
    mx = 316; my = 432; mdx = 2; mdy = -2; mst = 0; mcnt = 0;
  endfunction

  // One frame of game rules, written directly from the ball behaviour description.
  function automatic void model_tick();
    int p, nx, ny, wx, wdx;
    p = int'(pad);
    mmiss = 0;
    mhit = 0;
    if (mst == 0) begin
      mx = (p + 28 > 632) ? 632 : p + 28;
      my = 432;
      if (launch) begin mst = 1; mdx = 2; mdy = -2; end
    end else if (mst == 1) begin
      if (!pause) begin
        nx = mx + mdx;
        ny = my + mdy;
        wx = nx;
        wdx = mdx;
        if (nx <= 0) begin wx = 0; wdx = 2; end
        else if (nx + 8 >= 640) begin wx = 632; wdx = -2; end
        mhit = mdy > 0 && my + 8 <= 440 && ny + 8 > 440 && mx + 8 > p && mx < p + 64;
        if (mhit) begin mx = wx; mdx = wdx; my = 432; mdy = -2; end
        else if (ny >= 480) begin mst = 2; mcnt = 0; mmiss = 1; end
        else begin
          mx = wx; mdx = wdx;
          if (ny <= 0) begin my = 0; mdy = 2; end else my = ny;
        end
      end
    end else begin
      mcnt++;
      if (mcnt == 60) begin mst = 0; mcnt = 0; end
    end
  endfunction

  // Wrap py nonzero->0 to make exactly one frame tick, then compare against the model.
  task automatic do_tick(input string tag);
    misses = 0;
    py = 10'd1;
    cyc();
    py = 10'd0;
    repeat (4) cyc();
    model_tick();
    chk($sformatf("%s.x", tag), bx, mx);
    chk($sformatf("%s.y", tag), by, my);
    chk($sformatf("%s.state", tag), st, mst);
    chk($sformatf("%s.miss_cycles", tag), misses, mmiss ? 1 : 0);
  endtask

  task automatic chk_reset(input string tag);
    chk($sformatf("%s.x", tag), bx, 316);
    chk($sformatf("%s.y", tag), by, 432);
    chk($sformatf("%s.state", tag), st, 0);
    chk($sformatf("%s.r", tag), r, 0);
    chk($sformatf("%s.miss", tag), miss, 0);
  endtask

  // Short async reset pulse between clock edges; pending tick must be dropped.
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_reset(tag);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) cyc();
    chk_reset("rst");
    rst_n = 1'b1;
    repeat (4) cyc();
    chk("rst.no_tick_x", bx, 316);
    do_tick("serve1");
    chk("serve1.x128", bx, 128);
    launch = 1'b1;
    do_tick("launch");
    launch = 1'b0;
    repeat (3) do_tick("run3");
    chk("run3.x134", bx, 134);
    chk("run3.y426", by, 426);
    pause = 1'b1;
    repeat (5) do_tick("pause");
    chk("pause.x", bx, 134);
    chk("pause.y", by, 426);
    px = 10'd134; py = 10'd426; cyc();
    chk("rend.tl_r", r, 10'h3FF);
    chk("rend.tl_g", g, 10'h3FF);
    chk("rend.tl_b", b, 10'h3FF);
    px = 10'd141; py = 10'd433; cyc();
    chk("rend.br", r, 10'h3FF);
    px = 10'd142; py = 10'd426; cyc();
    chk("rend.right_out", r, 10'h000);
    px = 10'd134; py = 10'd434; cyc();
    chk("rend.below_out", r, 10'h000);
    px = 10'd133; py = 10'd430; cyc();
    chk("rend.left_out", r, 10'h000);
    do_tick("pause_end");
    pause = 1'b0;
    // reset with a tick pending in RUN; a leaked tick would move the ball to 28
    pad = 10'd0;
    py = 10'd1; cyc();
    py = 10'd0; cyc();
    pulse_reset("rst_run");
    repeat (5) cyc();
    chk("rst_run.no_tick_x", bx, 316);
    pad = 10'd101;
    do_tick("serve2");
    chk("serve2.x129", bx, 129);
    launch = 1'b1;
    do_tick("launch2");
    launch = 1'b0;
    for (int n = 1; n <= 253; n++) begin
      do_tick("wall");
      if (n == 216) chk("top.y0", by, 0);
      if (n == 251) chk("wall.x631", bx, 631);
      if (n == 252) chk("wall.x632", bx, 632);
      if (n == 253) chk("wall.x630", bx, 630);
    end
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      pad = 10'(mx >= 28 ? mx - 28 : 0);
      do_tick("track");
      if (mhit) begin
        chk("hit.y432", by, 432);
        do_tick("hit_next");
        chk("hit.y430", by, 430);
        done = 1;
      end
    end
    pad = 10'd900;
    for (int i = 0; i < 600 && mst != 2; i++) do_tick("fall1");
    chk("miss1.state", st, 2);
    repeat (30) do_tick("miss1_wait");
    pulse_reset("rst_miss");
    repeat (5) cyc();
    chk("rst_miss.no_tick_x", bx, 316);
    do_tick("serve_clamp");
    chk("serve_clamp.x632", bx, 632);
    launch = 1'b1;
    do_tick("launch3");
    launch = 1'b0;
    for (int i = 0; i < 600 && mst != 2; i++) do_tick("fall2");
    chk("miss2.state", st, 2);
    launch = 1'b1;
    repeat (59) do_tick("miss2_wait");
    chk("miss2.hold59", st, 2);
    do_tick("miss2_end");
    chk("miss2.serve60", st, 0);
    launch = 1'b0;
    for (int i = 0; i < 250; i++) begin
      pad = ($urandom_range(0, 3) == 0 || mst != 1) ? 10'($urandom_range(0, 1023))
                                                    : 10'(mx >= 28 ? mx - 28 : 0);
      launch = ($urandom_range(0, 9) < 3);
      pause = ($urandom_range(0, 9) == 0);
      do_tick("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ball_engine.md
BALL_ENGINE -- requirements
Module: ball_engine

Interface
REQ-001 The module SHALL have these parameters:
- BALL_SIZE, 8, ball edge length in pixels.
- SPEED, 2, pixels moved per axis per frame.
- PADDLE_Y, 440, top row of the paddle.
- PADDLE_W, 64, paddle width in pixels.
- MISS_FRAMES, 60, frames held in MISS.
REQ-002 The module SHALL have these ports:
- iCLK  in  1  pixel clock (VGA_CTRL_CLK domain).
- iRST_N  in  1  reset, asynchronous, active-low.
- px  in  10  current pixel X from vga_sync.
- py  in  10  current pixel Y from vga_sync.
- iPaddle_x  in  10  paddle left edge.
- iLaunch  in  1  serve request, active-high level.
- iPause  in  1  freeze motion, active-high level.
- oR, oG, oB  out  10 each  ball pixel colour.
- oBall_x  out  10  ball left edge.
- oBall_y  out  10  ball top edge.
- oState  out  2  state: 0 SERVE, 1 RUN, 2 MISS.
- oMiss  out  1  one-cycle pulse when the ball is lost.

Function
REQ-003 The frame tick SHALL assert for exactly one cycle, in the cycle after py changes from a nonzero value to 0 (registered previous py); all motion updates SHALL occur only on frame ticks.
REQ-004 Internal position and velocity SHALL use 11-bit signed arithmetic; dx and dy SHALL each be +SPEED or -SPEED only.
REQ-005 SERVE, on each tick: ball_x SHALL be set to iPaddle_x + PADDLE_W/2 - BALL_SIZE/2, clamped to [0, 640-BALL_SIZE]; ball_y SHALL be set to PADDLE_Y-BALL_SIZE.
REQ-006 SERVE to RUN SHALL occur on a tick with iLaunch=1, setting dx=+SPEED and dy=-SPEED; position SHALL not move on that tick.
REQ-007 RUN, on each tick with iPause=0, the block SHALL compute nx=x+dx and ny=y+dy, then:
- if nx<=0: x=0 and dx=+SPEED.
- else if nx+BALL_SIZE>=640: x=640-BALL_SIZE and dx=-SPEED.
- else: x=nx.
- Y SHALL be handled the same way at the top wall (ny<=0: y=0, dy=+SPEED).
REQ-008 Paddle hit: when dy>0, y+BALL_SIZE<=PADDLE_Y, ny+BALL_SIZE>PADDLE_Y, x+BALL_SIZE>iPaddle_x and x<iPaddle_x+PADDLE_W, the block SHALL set y=PADDLE_Y-BALL_SIZE and dy=-SPEED.
REQ-009 The paddle check SHALL take priority over the miss check; X and Y reflections on the same tick (corner) SHALL both apply.
REQ-010 Miss: with no paddle hit and ny>=480, the block SHALL enter MISS, pulse oMiss for one cycle, hold the position, and clear the frame counter.
REQ-011 MISS SHALL count ticks and return to SERVE on the tick that the count reaches MISS_FRAMES; iLaunch SHALL be ignored outside SERVE.
REQ-012 iPause=1 SHALL freeze position, velocity and state in RUN; SERVE tracking and the MISS count SHALL continue.
REQ-013 Render: oR/oG/oB SHALL be registered, one cycle after px/py, as 10'h3FF when ball_x<=px<ball_x+BALL_SIZE and ball_y<=py<ball_y+BALL_SIZE, otherwise 10'h000.
REQ-014 oBall_x, oBall_y and oState SHALL reflect the registered state with no extra latency.

Reset
REQ-015 iRST_N=0 SHALL immediately force the following, with no pending tick retained:
- state SERVE;
- ball_x=316, ball_y=PADDLE_Y-BALL_SIZE;
- dx=+SPEED, dy=-SPEED;
- colour outputs 0;
- oMiss 0;
- MISS counter 0;
- previous-py register 0.
REQ-016 Reset asserted mid-RUN or mid-MISS SHALL return the block to the REQ-015 values; after release, the first tick SHALL require a fresh py nonzero-to-0 wrap.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset with iPaddle_x=100, then one tick: ball_x=128, ball_y=432, oState=0.
- iLaunch on a tick, then 3 ticks: ball_x=134, ball_y=426, oState=1.
- In RUN at x=631, y=200 with dx=+2: after 1 tick x=632 and dx=-2; corner case at (0,0) with dx=-2, dy=-2: after 1 tick both velocities positive.
- Ball at y=431 with dy=+2 over iPaddle_x range: after 1 tick y=432 and dy=-2; same stimulus with the paddle away: ball continues, then at ny>=480 gets oMiss (1 cycle) and oState=2; after 60 ticks oState=0.
- iPause=1 for 5 ticks in RUN: position unchanged; with px=ball_x, py=ball_y, oR=3FF one cycle later; with px=ball_x+8, oR=0.
